// File: rtl/biquad_bank_sequencer.sv
// biquad_bank_sequencer
// Shares one double-biquad stage across a bank of bands, one sample per frame.
module biquad_bank_sequencer #(
   parameter int NUM_BANDS = 8,
   parameter int BAND_W    = $clog2(NUM_BANDS)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     sample_valid_in,
   input  logic signed [31:0]       sample_in,
   output logic                     busy_out,
   output logic [BAND_W-1:0]        band_idx_out,
   output logic                     bq_valid_out,
   output logic signed [31:0]       bq_x_n,
   output logic signed [31:0]       bq_x_n1,
   output logic signed [31:0]       bq_x_n2,
   output logic signed [31:0]       bq_i_n1,
   output logic signed [31:0]       bq_i_n2,
   output logic signed [31:0]       bq_y_n1,
   output logic signed [31:0]       bq_y_n2,
   input  logic signed [31:0]       bq_i_n_in,
   input  logic signed [31:0]       bq_y_n_in,
   input  logic                     bq_valid_in,
   output logic                     band_valid_out,
   output logic signed [31:0]       band_out,
   output logic [BAND_W-1:0]        band_res_idx_out,
   output logic                     frame_done_out,
   output logic                     overrun_out
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

   state_t state;
   state_t state_nxt;

   logic [BAND_W-1:0] band;
   logic              accept;
   logic              writeback;
   logic              last;

   logic signed [31:0] x_cur;
   logic signed [31:0] x_hist1;
   logic signed [31:0] x_hist2;
   logic signed [31:0] i_hist1 [NUM_BANDS];
   logic signed [31:0] i_hist2 [NUM_BANDS];
   logic signed [31:0] y_hist1 [NUM_BANDS];
   logic signed [31:0] y_hist2 [NUM_BANDS];

   assign last = (band == LAST_BAND);

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, start pulse and accept/writeback strobes
   always_comb begin
      state_nxt    = state;
      busy_out     = 1'b1;
      bq_valid_out = 1'b0;
      accept       = 1'b0;
      writeback    = 1'b0;
      unique case (state)
         IDLE: begin
            busy_out = 1'b0;
            if (sample_valid_in) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            bq_valid_out = 1'b1;
            state_nxt    = WAIT;
         end
         WAIT: begin
            if (bq_valid_in) begin
               writeback = 1'b1;
               state_nxt = last ? IDLE : ISSUE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Band counter, captured sample and shared input history
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         band    <= '0;
         x_cur   <= '0;
         x_hist1 <= '0;
         x_hist2 <= '0;
      end else begin
         if (accept) begin
            x_cur <= sample_in;
            band  <= '0;
         end
         if (writeback) begin
            if (last) begin
               x_hist2 <= x_hist1;
               x_hist1 <= x_cur;
            end else begin
               band <= band + BAND_W'(1);
            end
         end
      end
   end

   // Per-band intermediate and output history
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         i_hist1 <= '{default: '0};
         i_hist2 <= '{default: '0};
         y_hist1 <= '{default: '0};
         y_hist2 <= '{default: '0};
      end else if (writeback) begin
         i_hist2[band] <= i_hist1[band];
         i_hist1[band] <= bq_i_n_in;
         y_hist2[band] <= y_hist1[band];
         y_hist1[band] <= bq_y_n_in;
      end
   end

   // Band result register, result pulses and sticky overrun
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         band_out         <= '0;
         band_res_idx_out <= '0;
         band_valid_out   <= 1'b0;
         frame_done_out   <= 1'b0;
         overrun_out      <= 1'b0;
      end else begin
         band_valid_out <= writeback;
         frame_done_out <= writeback && last;
         if (writeback) begin
            band_out         <= bq_y_n_in;
            band_res_idx_out <= band;
         end
         if (sample_valid_in && busy_out) begin
            overrun_out <= 1'b1;
         end
      end
   end

   assign band_idx_out = band;
   assign bq_x_n       = x_cur;
   assign bq_x_n1      = x_hist1;
   assign bq_x_n2      = x_hist2;
   assign bq_i_n1      = i_hist1[band];
   assign bq_i_n2      = i_hist2[band];
   assign bq_y_n1      = y_hist1[band];
   assign bq_y_n2      = y_hist2[band];

endmodule

// File: tb/tb_biquad_bank_sequencer.sv
// tb_biquad_bank_sequencer
// Two-band bench with a behavioural double-biquad stage (pass-through coefs).
module tb_biquad_bank_sequencer;

   localparam int NB = 2;
   localparam int BW = $clog2(NB);

   localparam longint B0 = longint'(1) << 20;
   localparam longint B1 = 0;
   localparam longint B2 = 0;
   localparam longint A1 = 0;
   localparam longint A2 = 0;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                sample_valid_in;
   logic signed [31:0]  sample_in;
   logic                busy_out;
   logic [BW-1:0]       band_idx_out;
   logic                bq_valid_out;
   logic signed [31:0]  bq_x_n;
   logic signed [31:0]  bq_x_n1;
   logic signed [31:0]  bq_x_n2;
   logic signed [31:0]  bq_i_n1;
   logic signed [31:0]  bq_i_n2;
   logic signed [31:0]  bq_y_n1;
   logic signed [31:0]  bq_y_n2;
   logic signed [31:0]  bq_i_n_in;
   logic signed [31:0]  bq_y_n_in;
   logic                bq_valid_in;
   logic                band_valid_out;
   logic signed [31:0]  band_out;
   logic [BW-1:0]       band_res_idx_out;
   logic                frame_done_out;
   logic                overrun_out;

   int tests = 0;
   int fails = 0;
   int lat   = 2;
   int evq[$];

   logic signed [31:0] m_i;
   logic signed [31:0] m_y;

   typedef struct {
      bit                 rst;
      logic signed [31:0] s;
      logic signed [31:0] n1;
      logic signed [31:0] n2;
      int                 lat;
      int                 poke;
      bit                 ovr;
   } vec_t;

   vec_t vec [10];

   biquad_bank_sequencer #(
      .NUM_BANDS(NB)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .sample_valid_in (sample_valid_in),
      .sample_in       (sample_in),
      .busy_out        (busy_out),
      .band_idx_out    (band_idx_out),
      .bq_valid_out    (bq_valid_out),
      .bq_x_n          (bq_x_n),
      .bq_x_n1         (bq_x_n1),
      .bq_x_n2         (bq_x_n2),
      .bq_i_n1         (bq_i_n1),
      .bq_i_n2         (bq_i_n2),
      .bq_y_n1         (bq_y_n1),
      .bq_y_n2         (bq_y_n2),
      .bq_i_n_in       (bq_i_n_in),
      .bq_y_n_in       (bq_y_n_in),
      .bq_valid_in     (bq_valid_in),
      .band_valid_out  (band_valid_out),
      .band_out        (band_out),
      .band_res_idx_out(band_res_idx_out),
      .frame_done_out  (frame_done_out),
      .overrun_out     (overrun_out)
   );

   // Free-running clock
   always #5 clk_in = ~clk_in;

   function automatic logic signed [31:0] biq(
      input longint x0, input longint x1, input longint x2,
      input longint f1, input longint f2);
      longint acc;
      acc = B0 * x0 + B1 * x1 + B2 * x2 - A1 * f1 - A2 * f2;
      return 32'(acc >>> 20);
   endfunction

   // Behavioural double-biquad stage answering lat cycles after its start
   initial begin
      bq_valid_in = 1'b0;
      bq_i_n_in   = '0;
      bq_y_n_in   = '0;
      forever begin
         @(negedge clk_in);
         if (bq_valid_out) begin
            m_i = biq(bq_x_n, bq_x_n1, bq_x_n2, bq_i_n1, bq_i_n2);
            m_y = biq(m_i, bq_i_n1, bq_i_n2, bq_y_n1, bq_y_n2);
            repeat (lat) @(posedge clk_in);
            #1;
            bq_valid_in = 1'b1;
            bq_i_n_in   = m_i;
            bq_y_n_in   = m_y;
            @(posedge clk_in);
            #1;
            bq_valid_in = 1'b0;
         end
      end
   end

   // Hard stop if the sequence ever runs away
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic adv(input int poke, input logic signed [31:0] s,
                      inout int rel);
      step(1);
      rel++;
      if (band_valid_out) begin
         evq.push_back(int'(band_res_idx_out) * 2 + int'(frame_done_out));
      end
      sample_valid_in = (rel == poke);
      sample_in       = (rel == poke) ? 32'sh0BAD0BAD : s;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy"}, busy_out, 0);
      chk({tag, " bq_valid"}, bq_valid_out, 0);
      chk({tag, " band_valid"}, band_valid_out, 0);
      chk({tag, " frame_done"}, frame_done_out, 0);
      chk({tag, " overrun"}, overrun_out, 0);
      chk({tag, " band_out"}, band_out, 0);
      chk({tag, " res_idx"}, band_res_idx_out, 0);
      chk({tag, " band_idx"}, band_idx_out, 0);
      chk({tag, " x_n"}, bq_x_n, 0);
      chk({tag, " x_n1"}, bq_x_n1, 0);
      chk({tag, " x_n2"}, bq_x_n2, 0);
      chk({tag, " i_n1"}, bq_i_n1, 0);
      chk({tag, " i_n2"}, bq_i_n2, 0);
      chk({tag, " y_n1"}, bq_y_n1, 0);
      chk({tag, " y_n2"}, bq_y_n2, 0);
   endtask

   task automatic do_reset();
      rst_in          = 1'b1;
      sample_valid_in = 1'b0;
      sample_in       = '0;
      step(2);
      chk_zero("reset");
      rst_in = 1'b0;
      step(1);
   endtask

   task automatic run_frame(input string tag, input logic signed [31:0] s,
                            input logic signed [31:0] n1,
                            input logic signed [31:0] n2,
                            input int poke, input bit ovr);
      int rel = 0;
      evq.delete();
      chk({tag, " idle"}, busy_out, 0);
      sample_valid_in = 1'b1;
      sample_in       = s;
      adv(poke, s, rel);
      for (int b = 0; b < NB; b++) begin
         chk({tag, " start"}, bq_valid_out, 1);
         chk({tag, " band_idx"}, band_idx_out, b);
         chk({tag, " x_n"}, bq_x_n, s);
         chk({tag, " x_n1"}, bq_x_n1, n1);
         chk({tag, " x_n2"}, bq_x_n2, n2);
         chk({tag, " i_n1"}, bq_i_n1, n1);
         chk({tag, " i_n2"}, bq_i_n2, n2);
         chk({tag, " y_n1"}, bq_y_n1, n1);
         chk({tag, " y_n2"}, bq_y_n2, n2);
         for (int k = 0; k < lat; k++) begin
            adv(poke, s, rel);
            chk({tag, " hold start"}, bq_valid_out, 0);
            chk({tag, " hold busy"}, busy_out, 1);
            chk({tag, " hold idx"}, band_idx_out, b);
            chk({tag, " hold x_n"}, bq_x_n, s);
            chk({tag, " hold x_n1"}, bq_x_n1, n1);
            chk({tag, " hold y_n1"}, bq_y_n1, n1);
         end
         adv(poke, s, rel);
         chk({tag, " band_valid"}, band_valid_out, 1);
         chk({tag, " band_out"}, band_out, s);
         chk({tag, " res_idx"}, band_res_idx_out, b);
         chk({tag, " frame_done"}, frame_done_out, (b == NB - 1));
      end
      chk({tag, " rel"}, rel, 1 + NB * (lat + 1));
      chk({tag, " end busy"}, busy_out, 0);
      chk({tag, " end x_n1"}, bq_x_n1, s);
      chk({tag, " end x_n2"}, bq_x_n2, n1);
      chk({tag, " overrun"}, overrun_out, ovr);
      chk({tag, " pulses"}, evq.size(), NB);
      if (evq.size() == NB) begin
         chk({tag, " first"}, evq[0], 0);
         chk({tag, " last"}, evq[NB-1], (NB - 1) * 2 + 1);
      end
   endtask

   initial begin
      int rel;
      rst_in          = 1'b1;
      sample_valid_in = 1'b0;
      sample_in       = '0;

      vec[0] = '{1'b1, 32'sd1000, 32'sd0, 32'sd0, 2, -1, 1'b0};
      vec[1] = '{1'b0, 32'sd2000, 32'sd1000, 32'sd0, 2, -1, 1'b0};
      vec[2] = '{1'b0, -32'sd5, 32'sd2000, 32'sd1000, 2, -1, 1'b0};
      vec[3] = '{1'b0, 32'sh7FFFFFFF, -32'sd5, 32'sd2000, 2, -1, 1'b0};
      vec[4] = '{1'b0, 32'sh80000000, 32'sh7FFFFFFF, -32'sd5, 2, -1, 1'b0};
      vec[5] = '{1'b0, 32'sd3000, 32'sh80000000, 32'sh7FFFFFFF, 8, -1, 1'b0};
      vec[6] = '{1'b0, 32'sd4000, 32'sd3000, 32'sh80000000, 2, 2, 1'b1};
      vec[7] = '{1'b0, 32'sd4100, 32'sd4000, 32'sd3000, 2, -1, 1'b1};
      vec[8] = '{1'b1, 32'sd5000, 32'sd0, 32'sd0, 2, 6, 1'b1};
      vec[9] = '{1'b0, 32'sd6000, 32'sd5000, 32'sd0, 2, -1, 1'b1};

      for (int v = 0; v < 10; v++) begin
         if (vec[v].rst) begin
            do_reset();
         end
         lat = vec[v].lat;
         run_frame($sformatf("vec%0d", v), vec[v].s, vec[v].n1,
                   vec[v].n2, vec[v].poke, vec[v].ovr);
      end

      lat = 2;
      rel = 0;
      evq.delete();
      sample_valid_in = 1'b1;
      sample_in       = 32'sd7000;
      repeat (5) adv(-1, 32'sd7000, rel);
      chk("midrst busy", busy_out, 1);
      chk("midrst band", band_idx_out, 1);
      chk("midrst band0", band_out, 32'sd7000);
      rst_in = 1'b1;
      #1;
      chk_zero("midrst");
      #1;
      rst_in = 1'b0;
      repeat (5) adv(-1, 32'sd7000, rel);
      chk("midrst pulses", evq.size(), 1);
      chk("midrst late busy", busy_out, 0);
      chk("midrst late out", band_out, 0);
      chk("midrst late done", frame_done_out, 0);
      chk("midrst late x_n1", bq_x_n1, 0);

      run_frame("postrst", 32'sd8000, 32'sd0, 32'sd0, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
